// File: rtl/arb_requester.sv
// Client-side requester for a request/grant arbiter: queues burst commands, holds request
// until every beat of the active burst is granted, then drops request for one cycle.
module arb_requester #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned LEN_W   = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           cmd_valid,
  input  logic [LEN_W-1:0]               cmd_len,
  output logic                           cmd_ready,
  output logic                           request,
  input  logic                           grant,
  output logic                           beat,
  output logic                           done,
  output logic                           timeout_err,
  output logic [$clog2(DEPTH+1)-1:0]     pending
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = $clog2(DEPTH+1);
  localparam int unsigned WAIT_W = $clog2(TIMEOUT+1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  logic [LEN_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [1:0]        state_q, state_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              request_q;
  logic              timeout_q, timeout_d;
  logic              push, pop, empty;

  assign empty       = (count_q == '0);
  assign cmd_ready   = (count_q != CNT_W'(DEPTH));
  assign push        = cmd_valid & cmd_ready;
  assign pending     = count_q;
  assign request     = request_q;
  assign beat        = request_q & grant;
  assign done        = beat & (remaining_q == '0);
  assign timeout_err = timeout_q;

  // GAP pops directly when work is waiting, so back-to-back bursts see exactly one low cycle.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    wait_d      = wait_q;
    timeout_d   = 1'b0;
    pop         = 1'b0;
    unique case (state_q)
      IDLE, GAP: begin
        if (!empty) begin
          pop         = 1'b1;
          remaining_d = mem[rd_ptr_q];
          wait_d      = '0;
          state_d     = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (beat) begin
          if (remaining_q != '0) begin
            remaining_d = remaining_q - 1'b1;
            wait_d      = '0;
          end else begin
            state_d = GAP;
          end
        end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
          wait_d    = WAIT_W'(TIMEOUT);
          timeout_d = 1'b1;
          state_d   = GAP;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      wait_q      <= '0;
      request_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      wait_q      <= wait_d;
      request_q   <= (state_d == BUSY);
      timeout_q   <= timeout_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= cmd_len;
  end

endmodule

// File: tb/tb_arb_requester.sv
// Directed bench for arb_requester: scoreboard of expected burst lengths (0 = expect timeout)
// checked against beat/done/timeout_err, plus directed checks of latency, gaps and reset.
module tb_arb_requester;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic [3:0] cmd_len;
  logic       cmd_ready, request, grant, beat, done, timeout_err;
  logic [2:0] pending;
  logic       grant_en;

  int errors = 0;
  int checks = 0;
  int sb[$];
  int cur_beats = 0, cur_stall = 0, last_stall = 0;
  int done_cnt = 0, to_cnt = 0, warn_cnt = 0;

  arb_requester #(.DEPTH(4), .LEN_W(4), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_len(cmd_len),
    .cmd_ready(cmd_ready), .request(request), .grant(grant), .beat(beat),
    .done(done), .timeout_err(timeout_err), .pending(pending)
  );

  always #5 clk = ~clk;

  // Arbiter stand-in: grant is registered from the sampled request.
  always @(posedge clk or posedge reset) begin
    if (reset) grant <= 1'b0;
    else       grant <= grant_en & request;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer.
  always @(negedge clk or posedge reset) begin
    int exp_v;
    if (reset) begin
      cur_beats = 0;
      cur_stall = 0;
    end else begin
      if (grant && !request) warn_cnt++;
      if (beat) cur_beats++;
      if (request && !grant && cur_beats > 0) cur_stall++;
      if (done) begin
        exp_v = (sb.size() > 0) ? sb.pop_front() : -1;
        chk("sb_beats", cur_beats, exp_v);
        last_stall = cur_stall;
        done_cnt++;
        cur_beats = 0;
        cur_stall = 0;
      end
      if (timeout_err) begin
        exp_v = (sb.size() > 0) ? sb.pop_front() : -1;
        chk("sb_timeout", cur_beats, exp_v);
        to_cnt++;
        cur_beats = 0;
        cur_stall = 0;
      end
    end
  end

  // Call at posedge+1; returns at the next posedge+1 with the command pushed.
  task automatic push_cmd(input int len, input int exp);
    int n = 0;
    while (!cmd_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("push_ready", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_len   = 4'(len);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    sb.push_back(exp);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((sb.size() != 0 || request) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain", sb.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int n, b, hi, gaps, low, d0, t0;
    logic prev, seen;
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, b, hi, gaps, low, d0, t0;
    logic prev, seen;
    reset = 1'b1; cmd_valid = 1'b0; cmd_len = '0; grant_en = 1'b0;

    // Reset state
    repeat (2) @(posedge clk); #1;
    chk("rst_request", request, 0);
    chk("rst_pending", pending, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_beat", beat, 0);
    chk("rst_done", done, 0);
    chk("rst_timeout", timeout_err, 0);
    @(negedge clk); reset = 1'b0;

    // Single len=3 burst with grant following request
    grant_en = 1'b1;
    @(posedge clk); #1;
    push_cmd(3, 4);
    @(negedge clk);
    chk("t1_pending_queued", pending, 1);
    chk("t1_request_lat1", request, 0);
    @(negedge clk);
    chk("t1_request_lat2", request, 1);
    chk("t1_pending_active", pending, 0);
    n = 2;
    while (!done && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("t1_done_cycle", n, 6);
    @(negedge clk);
    chk("t1_gap_request", request, 0);
    chk("t1_gap_beat", beat, 0);
    @(negedge clk);
    chk("t1_idle_request", request, 0);
    drain(50);

    // Fill with grant low, then release: ordered bursts with one-cycle gaps
    grant_en = 1'b0;
    @(posedge clk); #1;
    push_cmd(0, 1);
    push_cmd(1, 2);
    push_cmd(2, 3);
    push_cmd(3, 4);
    @(negedge clk);
    chk("t2_pending3", pending, 3);
    chk("t2_ready3", cmd_ready, 1);
    @(posedge clk); #1;
    push_cmd(0, 1);
    @(negedge clk);
    chk("t2_pending_full", pending, 4);
    chk("t2_ready_full", cmd_ready, 0);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_len = 4'd7;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("t2_full_no_push", pending, 4);
    @(posedge clk); #1;
    grant_en = 1'b1;
    prev = request; seen = request; low = 0; gaps = 0; n = 0;
    while ((sb.size() != 0 || request) && n < 200) begin
      @(negedge clk);
      n++;
      if (request) begin
        if (!prev && seen) begin
          chk("t2_gap_len", low, 1);
          gaps++;
        end
        seen = 1'b1;
        low  = 0;
      end else begin
        low++;
      end
      prev = request;
    end
    chk("t2_gaps", gaps, 4);
    drain(50);

    // Push and pop in the same cycle with two entries queued
    grant_en = 1'b0;
    @(posedge clk); #1;
    push_cmd(0, 1);
    push_cmd(0, 1);
    push_cmd(0, 1);
    grant_en = 1'b1;
    n = 0;
    while (!done && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("t3_pending_before", pending, 2);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_len = 4'd1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    sb.push_back(2);
    @(negedge clk);
    chk("t3_pending_same", pending, 2);
    chk("t3_request_next", request, 1);
    drain(100);

    // len=5 with grant dropped for three cycles after the second beat
    grant_en = 1'b1;
    @(posedge clk); #1;
    push_cmd(5, 6);
    b = 0; n = 0;
    while (b < 2 && n < 30) begin
      @(negedge clk);
      n++;
      if (beat) b++;
    end
    chk("t4_two_beats", b, 2);
    @(posedge clk); #1;
    grant_en = 1'b0;
    repeat (3) @(posedge clk);
    #1 grant_en = 1'b1;
    drain(50);
    chk("t4_stall_cycles", last_stall, 3);

    // Timeout with grant never asserted; next command follows after one low cycle
    grant_en = 1'b0;
    @(posedge clk); #1;
    push_cmd(2, 0);
    push_cmd(1, 2);
    hi = 0; n = 0;
    while (!timeout_err && n < 40) begin
      @(negedge clk);
      n++;
      if (request) hi++;
    end
    chk("t5_wait_cycles", hi, 15);
    chk("t5_pulse", timeout_err, 1);
    chk("t5_gap_request", request, 0);
    @(negedge clk);
    chk("t5_pulse_width", timeout_err, 0);
    chk("t5_next_request", request, 1);
    @(posedge clk); #1;
    grant_en = 1'b1;
    drain(50);

    // Asynchronous reset mid-burst
    grant_en = 1'b1;
    @(posedge clk); #1;
    push_cmd(7, 8);
    push_cmd(1, 2);
    b = 0; n = 0;
    while (b < 2 && n < 30) begin
      @(negedge clk);
      n++;
      if (beat) b++;
    end
    chk("t6_pending_pre", pending, 1);
    #1 reset = 1'b1;
    #1;
    chk("t6_request_async", request, 0);
    chk("t6_pending_async", pending, 0);
    chk("t6_ready_async", cmd_ready, 1);
    sb.delete();
    d0 = done_cnt; t0 = to_cnt;
    grant_en = 1'b0;
    @(posedge clk); #2 reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("t6_no_done", done_cnt, d0);
    chk("t6_no_timeout", to_cnt, t0);
    chk("t6_idle_request", request, 0);

    $display("note: grant seen while request low on %0d cycles", warn_cnt);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
